// File: rtl/shift_register_universal.sv
// Universal WIDTH-bit shift register with hold/shift/load/rotate/ASR and an autonomous burst engine.
// Optional: define SHIFT_REG_ROTATE_EN to enable rotate modes 100/101 (otherwise they hold).
module shift_register_universal #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               so_q, so_d;
    logic               done_q, done_d;
    logic [2:0]         op_sel;
    logic               do_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 3'b000;
            cnt_q   <= '0;
            q_q     <= '0;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            so_q    <= so_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        do_op   = 1'b0;
        op_sel  = mode;
        unique case (state_q)
            StIdle: begin
                // start has priority over a single enable-driven operation
                if (start) begin
                    op_d  = mode;
                    cnt_d = count;
                    if (count != '0) begin
                        state_d = StRun;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (enable) begin
                    do_op = 1'b1;
                end
            end
            StRun: begin
                do_op  = 1'b1;
                op_sel = op_q;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        q_d  = q_q;
        so_d = so_q;
        if (do_op) begin
            case (op_sel)
                3'b001: begin
                    q_d  = {q_q[WIDTH-2:0], serial_in};
                    so_d = q_q[WIDTH-1];
                end
                3'b010: begin
                    q_d  = {serial_in, q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                3'b011: q_d = parallel_in;
`ifdef SHIFT_REG_ROTATE_EN
                3'b100: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    so_d = q_q[WIDTH-1];
                end
                3'b101: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
`endif
                3'b110: begin
                    q_d  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        q          = q_q;
        serial_out = so_q;
        busy       = (state_q == StRun);
        done       = done_q;
    end

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal: vector table, hand-written burst/reset
// sequences, and randomized stimulus against an arithmetic reference model.
module tb_shift_register_universal;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
`ifdef SHIFT_REG_ROTATE_EN
    localparam bit Rot = 1'b1;
`else
    localparam bit Rot = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, enable, serial_in, start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] parallel_in;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             serial_out, busy, done;

    int checks = 0;
    int failures = 0;

    shift_register_universal #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .serial_in(serial_in),
        .parallel_in(parallel_in), .start(start), .count(count), .q(q),
        .serial_out(serial_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       en;
        bit [2:0] md;
        bit       si;
        bit [7:0] pin;
        bit [7:0] exp_q;
        bit       exp_so;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference operation, expressed as arithmetic on the register value.
    function automatic void model_op(input int op, input int cur, input int cur_so, input int si,
                                     input int pin, output int nq, output int nso);
        int m, half;
        m    = 1 << WIDTH;
        half = 1 << (WIDTH - 1);
        nq   = cur;
        nso  = cur_so;
        case (op)
            1: begin nq = (cur * 2 + si) % m;                 nso = cur / half; end
            2: begin nq = cur / 2 + si * half;                nso = cur % 2;    end
            3: nq = pin;
            4: if (Rot) begin nq = (cur * 2) % m + cur / half; nso = cur / half; end
            5: if (Rot) begin nq = cur / 2 + (cur % 2) * half; nso = cur % 2;    end
            6: begin nq = cur / 2 + ((cur >= half) ? half : 0); nso = cur % 2;   end
            default: ;
        endcase
    endfunction

    task automatic idle_inputs();
        enable = 0; start = 0; mode = 0; serial_in = 0; parallel_in = 0; count = 0;
    endtask

    task automatic load(input logic [7:0] v);
        enable = 1; start = 0; mode = 3'b011; parallel_in = v;
        tick();
        idle_inputs();
    endtask

    vec_t vecs[12];

    initial begin
        int m_q, m_so, m_left, m_op, m_done, nq, nso;
        idle_inputs();
        reset = 1;

        // Reset dominates a concurrent load
        enable = 1; mode = 3'b011; parallel_in = 8'hFF;
        tick(); tick();
        check("rst_q", q, 0);
        check("rst_so", serial_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 0;
        idle_inputs();

        vecs[0]  = '{1, 3'b011, 0, 8'hA5, 8'hA5, 0};
        vecs[1]  = '{1, 3'b001, 1, 8'h00, 8'h4B, 1};
        vecs[2]  = '{1, 3'b011, 0, 8'h90, 8'h90, 1};
        vecs[3]  = '{1, 3'b110, 1, 8'h00, 8'hC8, 0};
        vecs[4]  = '{1, 3'b000, 1, 8'hFF, 8'hC8, 0};
        vecs[5]  = '{1, 3'b111, 1, 8'hFF, 8'hC8, 0};
        vecs[6]  = '{1, 3'b010, 1, 8'h00, 8'hE4, 0};
        vecs[7]  = '{0, 3'b011, 0, 8'h00, 8'hE4, 0};
        vecs[8]  = '{1, 3'b011, 0, 8'h81, 8'h81, 0};
        vecs[9]  = '{1, 3'b100, 0, 8'h00, Rot ? 8'h03 : 8'h81, Rot};
        vecs[10] = '{1, 3'b101, 0, 8'h00, 8'h81, Rot};
        vecs[11] = '{1, 3'b001, 0, 8'h00, 8'h02, 1};
        for (int i = 0; i < 12; i++) begin
            enable = vecs[i].en; mode = vecs[i].md; serial_in = vecs[i].si;
            parallel_in = vecs[i].pin;
            tick();
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_so", i), serial_out, vecs[i].exp_so);
        end
        idle_inputs();

        // Burst shift right x3 from 0x81, with ignored starts during busy
        load(8'h81);
        start = 1; mode = 3'b010; count = 3; serial_in = 0;
        tick();
        check("bsr_e0_busy", busy, 1);
        check("bsr_e0_q", q, 8'h81);
        start = 1; mode = 3'b011; count = 7; enable = 1; parallel_in = 8'hFF;
        tick();
        check("bsr_e1_q", q, 8'h40);
        check("bsr_e1_busy", busy, 1);
        tick();
        check("bsr_e2_q", q, 8'h20);
        check("bsr_e2_busy", busy, 1);
        check("bsr_e2_done", done, 0);
        tick();
        idle_inputs();
        check("bsr_e3_q", q, 8'h10);
        check("bsr_e3_so", serial_out, 0);
        check("bsr_e3_busy", busy, 0);
        check("bsr_e3_done", done, 1);
        tick();
        check("bsr_post_done", done, 0);
        check("bsr_post_q", q, 8'h10);

        // Rotate-left burst x2 from 0x81
        load(8'h81);
        start = 1; mode = 3'b100; count = 2;
        tick();
        idle_inputs();
        check("rol_e0_busy", busy, 1);
        tick();
        check("rol_e1_q", q, Rot ? 8'h03 : 8'h81);
        check("rol_e1_busy", busy, 1);
        tick();
        check("rol_e2_q", q, Rot ? 8'h06 : 8'h81);
        check("rol_e2_done", done, 1);
        check("rol_e2_busy", busy, 0);
        tick();
        check("rol_post_done", done, 0);

        // Reset during the 2nd cycle of a count=5 burst
        start = 1; mode = 3'b001; count = 5; serial_in = 1;
        tick();
        idle_inputs();
        tick();
        check("abort_e1_busy", busy, 1);
        reset = 1;
        tick();
        reset = 0;
        check("abort_q", q, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", done, 0);
        end

        // count=0 burst: done for one cycle, no busy, start beats enable
        load(8'h3C);
        start = 1; enable = 1; mode = 3'b011; parallel_in = 8'hFF; count = 0;
        tick();
        idle_inputs();
        check("c0_busy", busy, 0);
        check("c0_done", done, 1);
        check("c0_q", q, 8'h3C);
        tick();
        check("c0_done_end", done, 0);
        check("c0_busy_end", busy, 0);
        check("c0_q_end", q, 8'h3C);

        // Randomized phase against the reference model
        m_q = q; m_so = serial_out; m_left = 0; m_op = 0; m_done = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset       = ($urandom_range(63) == 0);
            start       = ($urandom_range(7) == 0);
            enable      = $urandom_range(1);
            mode        = 3'($urandom_range(7));
            serial_in   = $urandom_range(1);
            parallel_in = 8'($urandom_range(255));
            count       = 4'($urandom_range(6));
            if (reset) begin
                m_q = 0; m_so = 0; m_left = 0; m_done = 0;
            end else if (m_left > 0) begin
                model_op(m_op, m_q, m_so, serial_in, parallel_in, nq, nso);
                m_q = nq; m_so = nso;
                m_left--;
                m_done = (m_left == 0);
            end else if (start) begin
                m_op = mode; m_left = count; m_done = (count == 0);
            end else begin
                m_done = 0;
                if (enable) begin
                    model_op(mode, m_q, m_so, serial_in, parallel_in, nq, nso);
                    m_q = nq; m_so = nso;
                end
            end
            tick();
            check("rnd_q", q, m_q);
            check("rnd_so", serial_out, m_so);
            check("rnd_busy", busy, (m_left > 0) ? 1 : 0);
            check("rnd_done", done, m_done);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
